// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-4 stream demultiplexer.
// Each accepted word is steered by in_sel into one of four one-entry
// channel registers with independent valid/ready handshakes.
// Optional feature macro: DEMUX_COUNT_EN adds per-channel 8-bit
// delivered-word counters; without it cnt0..cnt3 are tied to zero.

// One output channel: EMPTY/FULL holding register plus optional counter.
module demux_chan #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [7:0]       cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next state: a write always leaves the channel FULL, even if the old
    // word is taken in the same cycle; a take without a write empties it.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (wr) state_nxt = FULL;
            FULL:    if (!wr && ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign valid = (state == FULL);

    // Data only moves on a write; it keeps its last value after delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  data <= '0;
        else if (wr) data <= wr_data;
    end

`ifdef DEMUX_COUNT_EN
    // Delivered-word counter, free-running wrap at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= 8'd0;
        else if (valid && ready) cnt <= cnt + 8'd1;
    end
`else
    assign cnt = 8'd0;
`endif
endmodule

module demux_stream #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0][WIDTH-1:0] out_data;
    logic [NUM_CH-1:0][7:0]       cnt;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH-1:0]            out_ready;
    logic [NUM_CH-1:0]            wr;
    logic                         accept;

    assign out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

    // Only the selected channel gates the producer, so a stalled channel
    // never blocks traffic bound for the others.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    // One-hot write strobe to the selected channel.
    always_comb begin
        wr = '0;
        if (accept) wr[in_sel] = 1'b1;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        demux_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (wr[k]),
            .wr_data (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .data    (out_data[k]),
            .cnt     (cnt[k])
        );
    end

    assign out0_data  = out_data[0];
    assign out1_data  = out_data[1];
    assign out2_data  = out_data[2];
    assign out3_data  = out_data[3];
    assign out0_valid = out_valid[0];
    assign out1_valid = out_valid[1];
    assign out2_valid = out_valid[2];
    assign out3_valid = out_valid[3];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];
    assign cnt2       = cnt[2];
    assign cnt3       = cnt[3];
endmodule

// File: tb/tb_demux_stream.sv
// Directed + scoreboarded random bench for demux_stream.
module tb_demux_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out0_data, out1_data, out2_data, out3_data;
    logic       out0_valid, out1_valid, out2_valid, out3_valid;
    logic [3:0] out_rdy;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;

    logic [1:0] od [4];
    logic [3:0] ov;
    logic [1:0] exp_q [4][$];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data), .out3_data(out3_data),
        .out0_valid(out0_valid), .out1_valid(out1_valid), .out2_valid(out2_valid), .out3_valid(out3_valid),
        .out0_ready(out_rdy[0]), .out1_ready(out_rdy[1]), .out2_ready(out_rdy[2]), .out3_ready(out_rdy[3]),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    assign od[0] = out0_data;
    assign od[1] = out1_data;
    assign od[2] = out2_data;
    assign od[3] = out3_data;
    assign ov    = {out3_valid, out2_valid, out1_valid, out0_valid};

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [1:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
    endtask

    task automatic chk_cnt_zero(input string tag);
`ifndef DEMUX_COUNT_EN
        chk(tag, {cnt3, cnt2, cnt1, cnt0}, 0);
`endif
    endtask

    // Pre-edge scoreboard step: a take pops the oldest expected word.
    task automatic score_takes();
        for (int k = 0; k < 4; k++) begin
            if (ov[k] && out_rdy[k]) begin
                if (exp_q[k].size() == 0) chk("rand_dup", 1, 0);
                else chk("rand_data", od[k], exp_q[k].pop_front());
            end
        end
    endtask

    initial begin
        int words;
        int cyc;
        logic acc;

        // ---------------- reset state ----------------
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 2'd0; out_rdy = 4'h0;
        #3;
        chk("rst_valid", ov, 0);
        chk("rst_data", {od[3], od[2], od[1], od[0]}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---------------- route to each channel ----------------
        out_rdy = 4'hf;
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 2'(k));
            #1;
            chk("route_in_ready", in_ready, 1);
            tick();
            chk("route_valid", ov, 1 << k);
            chk("route_data", od[k], k);
        end
        in_valid = 1'b0;
        tick();
        chk("route_pulse_end", ov, 0);
        chk_cnt_zero("cnt_off_route");

        // ---------------- stall isolation ----------------
        out_rdy = 4'b1011;
        send(2'd2, 2'b10);
        #1;
        chk("stall_first_rdy", in_ready, 1);
        tick();
        chk("stall_first_valid", out2_valid, 1);
        chk("stall_first_data", out2_data, 2);
        send(2'd2, 2'b01);
        #1;
        chk("stall_blocked", in_ready, 0);
        tick();
        chk("stall_hold_data", out2_data, 2);
        chk("stall_hold_valid", out2_valid, 1);
        chk("stall_still_blocked", in_ready, 0);
        chk("stall_ch1_idle", out1_valid, 0);
        out_rdy[2] = 1'b1;
        #1;
        chk("stall_release_rdy", in_ready, 1);
        tick();
        chk("stall_second_data", out2_data, 1);
        chk("stall_second_valid", out2_valid, 1);
        send(2'd1, 2'b11);
        tick();
        chk("stall_ch1_data", out1_data, 3);
        chk("stall_ch1_valid", out1_valid, 1);
        chk("stall_ch2_cleared", out2_valid, 0);
        in_valid = 1'b0;
        tick();

        // ---------------- simultaneous write and take ----------------
        out_rdy = 4'b0111;
        send(2'd3, 2'b01);
        tick();
        chk("wt_full", out3_valid, 1);
        chk("wt_old_data", out3_data, 1);
        out_rdy[3] = 1'b1;
        send(2'd3, 2'b10);
        #1;
        chk("wt_in_ready", in_ready, 1);
        tick();
        chk("wt_new_data", out3_data, 2);
        chk("wt_valid", out3_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("wt_drained", out3_valid, 0);
        chk("wt_data_held", out3_data, 2);

        // ---------------- mid-operation async reset ----------------
        out_rdy = 4'h0;
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 2'b11);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_all_full", ov, 4'hf);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid_clr", ov, 0);
        chk("mid_data_clr", {od[3], od[2], od[1], od[0]}, 0);
        chk("mid_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;
        tick();

        // ---------------- random with scoreboard ----------------
        words = 0; cyc = 0;
        while (words < 1000 && cyc < 20000) begin
            if (!in_valid && $urandom_range(3) != 0) send(2'($urandom_range(3)), 2'($urandom_range(3)));
            for (int k = 0; k < 4; k++) out_rdy[k] = ($urandom_range(3) != 0);
            #1;
            score_takes();
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q[in_sel].push_back(in_data);
                words++;
            end
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        chk("rand_word_count", words, 1000);
        in_valid = 1'b0;
        out_rdy  = 4'hf;
        for (int i = 0; i < 3; i++) begin
            #1;
            score_takes();
            tick();
        end
        for (int k = 0; k < 4; k++) chk("rand_lost", exp_q[k].size(), 0);
        chk_cnt_zero("cnt_off_rand");

`ifdef DEMUX_COUNT_EN
        // ---------------- counter wrap ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        out_rdy = 4'hf;
        send(2'd0, 2'b01);
        for (int i = 0; i < 257; i++) tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("cnt0_wrap", cnt0, 1);
        chk("cnt1_idle", cnt1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/demux_stream.md
# demux_stream

Registered 1-to-4 stream demultiplexer: the destination side of the 4:1 case-mux datapath. Each word accepted on the input port is steered by a 2-bit select to exactly one of four output channels. Each channel has a one-entry output register with valid/ready flow control, so a stalled channel never blocks words bound for the other three. The block sits between a single producer and four independent consumers in the 2-bit datapath.

## Interface
Parameters:
- WIDTH, 2, data word width in bits.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel, 0..3; sampled with in_data.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle (combinational).
- out0_data..out3_data  output  WIDTH each  channel registers.
- out0_valid..out3_valid  output  1 each  channel register holds an undelivered word.
- out0_ready..out3_ready  input  1 each  consumer takes the word this cycle.
- cnt0..cnt3  output  8 each  delivered-word counters (see Configuration).

Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

## Operation
- Per channel k, define `take_k = outk_valid & outk_ready`.
- in_ready = !out[in_sel]_valid | out[in_sel]_ready. The select acts as a case on in_sel, and in_ready depends only on the selected channel.
- accept = in_valid & in_ready. On accept, out[in_sel]_data <= in_data and out[in_sel]_valid <= 1.
- For each channel k that is not written this cycle: if take_k then outk_valid <= 0; otherwise it holds.
- If channel k is written and taken in the same cycle, the new word is loaded and valid stays 1. Throughput is 1 word/cycle into a channel whose consumer is always ready.
- outk_data only changes on a write to channel k. It holds while valid & !ready, and it holds its last value after it is taken.
- Unselected channels are never disturbed by input traffic.
- in_data and in_sel are don't-care while in_valid = 0.
- No reordering within a channel; the order across channels follows input order.
- Output state per channel is 2-state: EMPTY (valid = 0) and FULL (valid = 1).
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on take without a write.
  - FULL -> FULL on write with take, or when there is no take.

## Timing
- Reset (async assert, any time including mid-transfer): all outk_valid = 0, all outk_data = 0, all cnt = 0. Pending words are dropped.
- in_ready is combinational; in_ready = 1 while in reset.
- Synchronous release: the first accept is possible on the first rising edge after rst_n goes high.
- Latency: a word accepted at edge N appears on outk_data with outk_valid = 1 right after edge N, and is visible in cycle N+1.
- Backpressure: channel k FULL and outk_ready = 0 gives in_ready = 0 only while in_sel = k. The producer must hold in_data, in_sel and in_valid until accepted.

## Configuration
- DEMUX_COUNT_EN defined: each cntk is an 8-bit counter incremented on take_k. It wraps 255 -> 0, with no saturation.
- DEMUX_COUNT_EN undefined: counter logic is not compiled and cnt0..cnt3 are tied to 8'd0. The ports remain present so the port list is identical in both builds.

## Test plan
- Reset then route: in_sel = 0..3 with in_data = 2'b00, 01, 10, 11, and all readies high. Each outk_data equals k one cycle after its accept, outk_valid pulses one cycle, and in_ready stays 1.
- Stall isolation: out2_ready = 0, send in_sel = 2 twice, then in_sel = 1.
  - The first word goes to out2.
  - in_ready = 0 while the second word waits.
  - The producer holds the second word; after out2_ready rises it is delivered.
  - The in_sel = 1 word is delivered only after the stalled word clears.
- Simultaneous write and take: channel 3 FULL with data 01, out3_ready = 1, and an accept of 10 to channel 3 in the same cycle. Next cycle out3_data = 10, out3_valid = 1, in_ready was 1.
- Mid-operation reset: all channels FULL, pulse rst_n low between edges. All valids and data go to 0 immediately (asynchronous), and in_ready = 1.
- Random stimulus: 1000 words, $random select, random readies. A scoreboard compares each channel's delivered sequence against a per-channel FIFO model. No loss, no duplication, in order.
- Counters: with DEMUX_COUNT_EN, deliver 257 words to channel 0 and cnt0 = 1. Without the macro, all cnt = 0 throughout.
